pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the pipelined ARM core. It replaces the fixed FWDA/FWDB and IF_ID_flush signals with a sequential scoreboard.
- The scoreboard tracks every in-flight register write across a configurable number of post-decode pipeline registers.
- It issues registered forwarding selects to EX, load-use and flag-use stalls, branch flushes, and whole-pipeline freezes for a multi-cycle data memory.
- Sits beside IF_ID_Reg/ID_EX_Reg and receives decode-stage fields from CPU_control.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/hazard_scoreboard.sv | 58 +++++
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline hazard controller.
// Scoreboard entry layout and forwarding-select helpers.
package pipe_pkg;

  localparam int NREG_MAX = 8;
  localparam int FWD_REGFILE = 0;

  // All-ones index; sliced to the core's register width at the use site.
  localparam logic [NREG_MAX-1:0] XZR = '1;

  typedef struct packed {
    logic                v;
    logic [NREG_MAX-1:0] rd;
    logic                ld;
    logic                sf;
  } sb_entry_t;

  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination shift register plus a
// youngest-match priority encoder for each ID source operand.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter  int DEPTH  = 3,
  parameter  int NREG_W = 5,
  localparam int FW     = fwd_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  sb_entry_t         ins,
  input  logic [NREG_W-1:0] src [2],
  input  logic              use_src [2],
  output logic              hit [2],
  output logic [FW-1:0]     hit_slot [2],
  output logic              hit_ld [2],
  output logic              flags_pending
);

  sb_entry_t slot [1:DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 1; j <= DEPTH; j++) begin
        slot[j] <= '0;
      end
    end else if (shift) begin
      slot[1] <= ins;
      for (int j = 2; j <= DEPTH; j++) begin
        slot[j] <= slot[j-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s]      = 1'b0;
      hit_slot[s] = '0;
      hit_ld[s]   = 1'b0;
      for (int j = DEPTH; j >= 1; j--) begin
        if (use_src[s] &&
            src[s] != XZR[NREG_W-1:0] &&
            slot[j].v &&
            slot[j].rd == NREG_MAX'(src[s])) begin
          hit[s]      = 1'b1;
          hit_slot[s] = FW'(j);
          hit_ld[s]   = slot[j].ld;
        end
      end
    end
  end

  assign flags_pending = slot[1].v && slot[1].sf;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding selects, load/flag stalls, branch
// flushes and memory freezes driven by an in-flight write scoreboard.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter  int DEPTH     = 3,
  parameter  int LOAD_SLOT = 3,
  parameter  int NREG_W    = 5,
  parameter  int CNT_W     = 16,
  localparam int FW        = fwd_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [NREG_W-1:0] id_rn,
  input  logic [NREG_W-1:0] id_rm,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic [NREG_W-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_uses_flags,
  input  logic              id_set_flags,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic              stall,
  output logic              freeze,
  output logic              flush_if_id,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [NREG_W-1:0] src [2];
  logic              use_src [2];
  logic              hit [2];
  logic [FW-1:0]     hit_slot [2];
  logic              hit_ld [2];
  logic              flags_pending;

  logic              load_use;
  logic              flag_hz;
  logic              stall_raw;
  logic              flush_raw;
  logic [FW-1:0]     fwd_nxt [2];

  sb_entry_t         ins;
  logic [FW-1:0]     fa_d, fb_d;
  logic [CNT_W-1:0]  sc_d, fc_d;

  assign src[0]     = id_rn;
  assign src[1]     = id_rm;
  assign use_src[0] = id_use_rn;
  assign use_src[1] = id_use_rm;

  hazard_scoreboard #(
    .DEPTH  (DEPTH),
    .NREG_W (NREG_W)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .shift         (!mem_busy),
    .ins           (ins),
    .src           (src),
    .use_src       (use_src),
    .hit           (hit),
    .hit_slot      (hit_slot),
    .hit_ld        (hit_ld),
    .flags_pending (flags_pending)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Producer in slot j is in slot j+1 when the consumer reaches EX;
  // the oldest slot writes through the regfile instead.
  always_comb begin
    load_use = 1'b0;
    for (int s = 0; s < 2; s++) begin
      fwd_nxt[s] = FW'(FWD_REGFILE);
      if (hit[s] && int'(hit_slot[s]) < DEPTH) begin
        fwd_nxt[s] = hit_slot[s] + FW'(1);
      end
      if (hit[s] && hit_ld[s] &&
          int'(hit_slot[s]) + 1 < LOAD_SLOT) begin
        load_use = 1'b1;
      end
    end
  end

  assign flag_hz   = id_uses_flags && flags_pending;
  assign flush_raw = ex_branch_taken && !mem_busy;
  assign stall_raw = id_valid && (load_use || flag_hz) &&
                     !ex_branch_taken && !mem_busy;

  assign stall       = stall_raw && !rst;
  assign flush_if_id = flush_raw && !rst;
  assign freeze      = mem_busy && !rst;

  always_comb begin
    fa_d = fwd_a;
    fb_d = fwd_b;
    sc_d = stall_cnt;
    fc_d = flush_cnt;
    ins  = '0;
    unique case (1'b1)
      mem_busy: begin
      end
      flush_raw: begin
        fa_d = FW'(FWD_REGFILE);
        fb_d = FW'(FWD_REGFILE);
        fc_d = sat_inc(flush_cnt);
      end
      stall_raw: begin
        fa_d = FW'(FWD_REGFILE);
        fb_d = FW'(FWD_REGFILE);
        sc_d = sat_inc(stall_cnt);
      end
      default: begin
        fa_d   = fwd_nxt[0];
        fb_d   = fwd_nxt[1];
        ins.v  = id_valid && id_reg_write;
        ins.rd = NREG_MAX'(id_rd);
        ins.ld = id_mem_read;
        ins.sf = id_set_flags;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a     <= FW'(FWD_REGFILE);
      fwd_b     <= FW'(FWD_REGFILE);
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      fwd_a     <= fa_d;
      fwd_b     <= fb_d;
      stall_cnt <= sc_d;
      flush_cnt <= fc_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two configurations in lockstep, directed
// vectors feeding a queue scoreboard checked at each negedge.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_use_rn, id_use_rm;
  logic       id_reg_write, id_mem_read, id_uses_flags, id_set_flags;
  logic       ex_branch_taken, mem_busy;
  logic [4:0] id_rn, id_rm, id_rd;

  logic [1:0]  a_fa, a_fb;
  logic        a_st, a_fz, a_fl;
  logic [15:0] a_sc, a_fc;
  logic [2:0]  b_fa, b_fb;
  logic        b_st, b_fz, b_fl;
  logic [1:0]  b_sc, b_fc;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_uses_flags(id_uses_flags),
    .id_set_flags(id_set_flags), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .fwd_a(a_fa), .fwd_b(a_fb),
    .stall(a_st), .freeze(a_fz), .flush_if_id(a_fl),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  pipe_hazard_ctrl #(
    .DEPTH(5), .LOAD_SLOT(4), .NREG_W(5), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_uses_flags(id_uses_flags),
    .id_set_flags(id_set_flags), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .fwd_a(b_fa), .fwd_b(b_fb),
    .stall(b_st), .freeze(b_fz), .flush_if_id(b_fl),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rd, rn, rm;
    logic       urn, urm, rw, mr, uf, sf;
  } ins_t;

  typedef struct {
    int sel, vec;
    int st, fl, fz, fa, fb, sc, fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int vec = 0;

  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic ins_t alu(int rd, int rn, int rm, bit sf = 1'b0);
    ins_t i = '0;
    i.v = 1'b1; i.rd = 5'(rd); i.rn = 5'(rn); i.rm = 5'(rm);
    i.urn = 1'b1; i.urm = 1'b1; i.rw = 1'b1; i.sf = sf;
    return i;
  endfunction

  function automatic ins_t ldur(int rd, int rn);
    ins_t i = '0;
    i.v = 1'b1; i.rd = 5'(rd); i.rn = 5'(rn);
    i.urn = 1'b1; i.rw = 1'b1; i.mr = 1'b1;
    return i;
  endfunction

  function automatic ins_t bcond();
    ins_t i = '0;
    i.v = 1'b1; i.uf = 1'b1;
    return i;
  endfunction

  task automatic cyc(input int sel, input ins_t i,
                     input bit r, input bit br, input bit busy,
                     input bit chk,
                     input int st, input int fl, input int fz,
                     input int fa, input int fb,
                     input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    id_valid = i.v; id_rd = i.rd; id_rn = i.rn; id_rm = i.rm;
    id_use_rn = i.urn; id_use_rm = i.urm;
    id_reg_write = i.rw; id_mem_read = i.mr;
    id_uses_flags = i.uf; id_set_flags = i.sf;
    ex_branch_taken = br; mem_busy = busy;
    if (chk) begin
      e = '{sel, vec, st, fl, fz, fa, fb, sc, fc};
      q.push_back(e);
    end
    vec++;
  endtask

  task automatic chk(input string name, input int v,
                     input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d", name, v, got, want);
    end
  endtask

  initial begin
    exp_t e;
    int g_st, g_fl, g_fz, g_fa, g_fb, g_sc, g_fc;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 0) begin
          g_st = int'(a_st); g_fl = int'(a_fl); g_fz = int'(a_fz);
          g_fa = int'(a_fa); g_fb = int'(a_fb);
          g_sc = int'(a_sc); g_fc = int'(a_fc);
        end else begin
          g_st = int'(b_st); g_fl = int'(b_fl); g_fz = int'(b_fz);
          g_fa = int'(b_fa); g_fb = int'(b_fb);
          g_sc = int'(b_sc); g_fc = int'(b_fc);
        end
        chk("stall", e.vec, g_st, e.st);
        chk("flush_if_id", e.vec, g_fl, e.fl);
        chk("freeze", e.vec, g_fz, e.fz);
        chk("fwd_a", e.vec, g_fa, e.fa);
        chk("fwd_b", e.vec, g_fb, e.fb);
        chk("stall_cnt", e.vec, g_sc, e.sc);
        chk("flush_cnt", e.vec, g_fc, e.fc);
      end
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rd = '0; id_rn = '0; id_rm = '0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_reg_write = 1'b0;
    id_mem_read = 1'b0; id_uses_flags = 1'b0; id_set_flags = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);

    // default config: reset state and ALU forwarding distances
    cyc(0, nop(),         1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(0, alu(1, 2, 3),  0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(0, alu(2, 1, 3),  0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(0, alu(4, 1, 5),  0, 0, 0, 1,  0, 0, 0, 2, 0, 0, 0);
    cyc(0, alu(6, 1, 2),  0, 0, 0, 1,  0, 0, 0, 3, 0, 0, 0);
    cyc(0, nop(),         0, 0, 0, 1,  0, 0, 0, 0, 3, 0, 0);
    // load-use, one bubble, then forward from slot 3
    cyc(0, ldur(5, 7),    0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(0, alu(6, 5, 5),  0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    cyc(0, alu(6, 5, 5),  0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0);
    cyc(0, nop(),         0, 0, 0, 1,  0, 0, 0, 3, 3, 1, 0);
    // flags, then XZR load never stalls
    cyc(0, alu(9, 10, 11, 1), 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, bcond(),       0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 0);
    cyc(0, bcond(),       0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0);
    cyc(0, ldur(31, 1),   0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0);
    cyc(0, alu(3, 31, 31), 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0);
    cyc(0, nop(),         0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0);
    // taken branch over a load-use hazard
    cyc(0, ldur(5, 7),    0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0);
    cyc(0, alu(6, 5, 5),  0, 1, 0, 1,  0, 1, 0, 0, 0, 2, 0);
    cyc(0, alu(8, 6, 0),  0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1);
    cyc(0, nop(),         0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1);
    // dual-source forward held across a 3-cycle memory freeze
    cyc(0, alu(1, 2, 3),  0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1);
    cyc(0, alu(4, 1, 1),  0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 1);
    cyc(0, alu(7, 4, 0),  0, 0, 1, 1,  0, 0, 1, 2, 2, 2, 1);
    cyc(0, alu(7, 4, 0),  0, 1, 1, 1,  0, 0, 1, 2, 2, 2, 1);
    cyc(0, alu(7, 4, 0),  0, 0, 1, 1,  0, 0, 1, 2, 2, 2, 1);
    cyc(0, alu(7, 4, 0),  0, 0, 0, 1,  0, 0, 0, 2, 2, 2, 1);
    cyc(0, nop(),         0, 0, 0, 1,  0, 0, 0, 2, 0, 2, 1);

    // DEPTH=5 LOAD_SLOT=4 CNT_W=2
    cyc(1, nop(),         1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    cyc(1, nop(),         1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(1, ldur(5, 7),    0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(1, alu(6, 5, 5),  0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    cyc(1, alu(6, 5, 5),  0, 0, 0, 1,  1, 0, 0, 0, 0, 1, 0);
    cyc(1, alu(6, 5, 5),  0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0);
    cyc(1, nop(),         0, 0, 0, 1,  0, 0, 0, 4, 4, 2, 0);
    cyc(1, ldur(5, 7),    0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0);
    cyc(1, alu(9, 1, 2),  0, 0, 0, 1,  0, 0, 0, 0, 0, 2, 0);
    cyc(1, alu(6, 5, 5),  0, 0, 0, 1,  1, 0, 0, 0, 0, 2, 0);
    cyc(1, alu(6, 5, 5),  0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0);
    cyc(1, nop(),         0, 0, 0, 1,  0, 0, 0, 4, 4, 3, 0);
    cyc(1, ldur(5, 7),    0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0);
    cyc(1, alu(9, 1, 2),  0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0);
    cyc(1, alu(10, 1, 2), 0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0);
    cyc(1, alu(6, 5, 5),  0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0);
    cyc(1, nop(),         0, 0, 0, 1,  0, 0, 0, 4, 4, 3, 0);
    // counter saturation, then reset during a stall
    cyc(1, alu(11, 1, 2, 1), 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0);
    cyc(1, bcond(),       0, 0, 0, 1,  1, 0, 0, 0, 0, 3, 0);
    cyc(1, bcond(),       0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0);
    cyc(1, ldur(5, 7),    0, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0);
    cyc(1, alu(6, 5, 5),  0, 0, 0, 1,  1, 0, 0, 0, 0, 3, 0);
    cyc(1, alu(6, 5, 5),  1, 0, 0, 1,  0, 0, 0, 0, 0, 3, 0);
    cyc(1, alu(6, 5, 5),  0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(1, nop(),         0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
